// File: rtl/rf_pkg.sv
// Shared widths and requester identifiers for the register-file write arbiter.
package rf_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 3;
    localparam int unsigned CNT_W      = 8;

    localparam logic SRC_REQ0 = 1'b0;
    localparam logic SRC_REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; prio names the requester that wins a tie.
module rr_arb2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    logic prio;
    logic prio_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= SRC_REQ0;
        end else begin
            prio <= prio_nxt;
        end
    end

    // After serving one side, the other side wins the next tie.
    always_comb begin
        prio_nxt = prio;
        if (gnt[0]) begin
            prio_nxt = SRC_REQ1;
        end else if (gnt[1]) begin
            prio_nxt = SRC_REQ0;
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (prio == SRC_REQ1) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbitration of two writeback requesters onto one register-file write port
// through a one-deep output register.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_sel,
    input  logic              rf_ready,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic [1:0] gnt;
    logic       can_load;
    logic       arb_en;

    assign can_load = ~rf_we | rf_ready;
    assign arb_en   = can_load & ~rst;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1_valid, req0_valid}),
        .enable (arb_en),
        .gnt    (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    // Output register: load on grant, retire on accept, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            rf_sel   <= SRC_REQ0;
        end else if (gnt[0]) begin
            rf_we    <= 1'b1;
            rf_waddr <= req0_addr;
            rf_wdata <= req0_data;
            rf_sel   <= SRC_REQ0;
        end else if (gnt[1]) begin
            rf_we    <= 1'b1;
            rf_waddr <= req1_addr;
            rf_wdata <= req1_data;
            rf_sel   <= SRC_REQ1;
        end else if (rf_ready) begin
            rf_we    <= 1'b0;
        end
    end

    // Counts contention cycles whether or not a grant happens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (req0_valid && req1_valid && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: per-cycle model comparison plus directed scenarios.
module tb_rf_write_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [2:0] req0_addr, req1_addr;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       rf_we;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       rf_sel;
    logic       rf_ready;
    logic [7:0] conflict_cnt;

    int checks   = 0;
    int failures = 0;

    // Model state: the pending write, who was served last, contention count.
    logic       m_we;
    logic [2:0] m_addr;
    logic [7:0] m_data;
    logic       m_sel;
    logic       m_last;
    int         m_cnt;

    rf_write_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .rf_sel       (rf_sel),
        .rf_ready     (rf_ready),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ties go to whoever was not served most recently; a full, stalled register blocks everyone.
    function automatic logic [1:0] model_grant();
        if (rst || (m_we && !rf_ready)) return 2'b00;
        if (req0_valid && req1_valid) return m_last ? 2'b01 : 2'b10;
        return {req1_valid, req0_valid};
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [1:0] g;
        if (rst) begin
            m_we <= 1'b0; m_addr <= '0; m_data <= '0; m_sel <= 1'b0;
            m_last <= 1'b1; m_cnt <= 0;
        end else begin
            g = model_grant();
            if (g[0]) begin
                m_we <= 1'b1; m_addr <= req0_addr; m_data <= req0_data; m_sel <= 1'b0; m_last <= 1'b0;
            end else if (g[1]) begin
                m_we <= 1'b1; m_addr <= req1_addr; m_data <= req1_data; m_sel <= 1'b1; m_last <= 1'b1;
            end else if (m_we && rf_ready) begin
                m_we <= 1'b0;
            end
            if (req0_valid && req1_valid && m_cnt < 255) m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        logic [1:0] g;
        g = model_grant();
        chk("m_ready0", 32'(req0_ready), 32'(g[0]));
        chk("m_ready1", 32'(req1_ready), 32'(g[1]));
        chk("m_we", 32'(rf_we), 32'(m_we));
        chk("m_waddr", 32'(rf_waddr), 32'(m_addr));
        chk("m_wdata", 32'(rf_wdata), 32'(m_data));
        chk("m_sel", 32'(rf_sel), 32'(m_sel));
        chk("m_cnt", 32'(conflict_cnt), 32'(m_cnt));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic r0, r1;
        rst = 1'b1; rf_ready = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;

        // Reset: ready suppressed even with both valid
        repeat (2) @(posedge clk);
        #1 req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_cnt", 32'(conflict_cnt), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;

        // Single requester
        tick();
        req1_valid = 1'b1; req1_addr = 3'd5; req1_data = 8'hA7; rf_ready = 1'b1;
        #1 chk("single_ready1", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        chk("single_we", 32'(rf_we), 32'd1);
        chk("single_waddr", 32'(rf_waddr), 32'd5);
        chk("single_wdata", 32'(rf_wdata), 32'hA7);
        chk("single_sel", 32'(rf_sel), 32'd1);
        tick();
        chk("idle_we", 32'(rf_we), 32'd0);

        // Same address from both sides
        req0_valid = 1'b1; req0_addr = 3'd2; req0_data = 8'h11;
        req1_valid = 1'b1; req1_addr = 3'd2; req1_data = 8'h22;
        #1 chk("same_first", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        chk("same_w1", 32'(rf_wdata), 32'h11);
        #1 chk("same_second", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        chk("same_w2", 32'(rf_wdata), 32'h22);
        chk("same_addr", 32'(rf_waddr), 32'd2);
        chk("same_cnt", 32'(conflict_cnt), 32'd1);

        // Contention: strict alternation starting with req0
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("cont_gnt1", 32'(req1_ready), 32'(i % 2));
            chk("cont_gnt0", 32'(req0_ready), 32'((i + 1) % 2));
            tick();
        end
        chk("cont_cnt", 32'(conflict_cnt), 32'd7);

        // Back-pressure with both still valid
        rf_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready0", 32'(req0_ready), 32'd0);
            chk("bp_ready1", 32'(req1_ready), 32'd0);
            chk("bp_we", 32'(rf_we), 32'd1);
            chk("bp_wdata", 32'(rf_wdata), 32'h22);
            tick();
        end
        rf_ready = 1'b1;
        #1 chk("bp_release", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("bp_sel", 32'(rf_sel), 32'd0);
        chk("bp_cnt", 32'(conflict_cnt), 32'd11);

        // Reset while a write is held in the output register
        tick();
        rf_ready = 1'b0;
        req1_valid = 1'b1; req1_addr = 3'd6; req1_data = 8'h5C;
        tick();
        req1_valid = 1'b0;
        chk("mid_we_before", 32'(rf_we), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_we", 32'(rf_we), 32'd0);
        chk("mid_sel", 32'(rf_sel), 32'd0);
        chk("mid_cnt", 32'(conflict_cnt), 32'd0);
        tick();
        #1 rst = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1 chk("post_rst_tie", 32'(req0_ready), 32'd1);

        // Saturation
        rf_ready = 1'b1;
        repeat (300) tick();
        chk("sat_cnt", 32'(conflict_cnt), 32'd255);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Random traffic with protocol-compliant requesters
        for (int i = 0; i < 300; i++) begin
            r0 = req0_ready; r1 = req1_ready;
            tick();
            if (!req0_valid || r0) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_addr  = 3'($urandom); req0_data = 8'($urandom);
            end
            if (!req1_valid || r1) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_addr  = 3'($urandom); req1_data = 8'($urandom);
            end
            rf_ready = ($urandom_range(0, 3) != 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rf_ready = 1'b1;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
